// File: rtl/mem_wb_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_pipe
//  Description : DEPTH-stage MEM->WB register chain with valid/ready handshake,
//                flush, occupancy and an in-flight register-forwarding lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_pipe #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [DATA_W-1:0]            in_imm,
    input  logic [RADDR_W-1:0]           in_rd,
    input  logic                         in_regwrite,
    input  logic                         in_branchtaken,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [DATA_W-1:0]            out_imm,
    output logic [RADDR_W-1:0]           out_rd,
    output logic                         out_regwrite,
    output logic                         out_branchtaken,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    input  logic [RADDR_W-1:0]           fwd_rs,
    output logic                         fwd_hit,
    output logic [DATA_W-1:0]            fwd_data
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("mem_wb_pipe: DEPTH must be in 1..4");
        end
    endgenerate

    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   valid_d;
    logic [DATA_W-1:0]  data_q [DEPTH];
    logic [DATA_W-1:0]  imm_q  [DEPTH];
    logic [RADDR_W-1:0] rd_q   [DEPTH];
    logic [DEPTH-1:0]   rw_q;
    logic [DEPTH-1:0]   bt_q;

    logic [DEPTH-1:0]   w_rdy;
    logic [OCC_W-1:0]   w_occ;

    // Unrolled form of rdy[i] = !valid[i] | rdy[i+1]: a stage can move when the
    // consumer is ready or any stage at or beyond it is a bubble.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_rdy[i] = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                if (!valid_q[j]) begin
                    w_rdy[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                if (w_rdy[i]) begin
                    valid_d[i] = valid_q[i-1];
                end
            end
            if (w_rdy[0]) begin
                valid_d[0] = in_valid;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            rw_q    <= '0;
            bt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                imm_q[i]  <= '0;
                rd_q[i]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            if (!flush) begin
                for (int i = DEPTH - 1; i > 0; i--) begin
                    if (w_rdy[i]) begin
                        data_q[i] <= data_q[i-1];
                        imm_q[i]  <= imm_q[i-1];
                        rd_q[i]   <= rd_q[i-1];
                        rw_q[i]   <= rw_q[i-1];
                        bt_q[i]   <= bt_q[i-1];
                    end
                end
                if (w_rdy[0]) begin
                    data_q[0] <= in_data;
                    imm_q[0]  <= in_imm;
                    rd_q[0]   <= in_rd;
                    rw_q[0]   <= in_regwrite;
                    bt_q[0]   <= in_branchtaken;
                end
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(valid_q[i]);
        end
    end

    // Scan oldest to youngest so the youngest matching stage overwrites the result.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && rw_q[i] && (rd_q[i] == fwd_rs) && (fwd_rs != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[i];
            end
        end
    end

    assign in_ready        = w_rdy[0] & ~flush;
    assign out_valid       = valid_q[DEPTH-1];
    assign out_data        = data_q[DEPTH-1];
    assign out_imm         = imm_q[DEPTH-1];
    assign out_rd          = rd_q[DEPTH-1];
    assign out_regwrite    = rw_q[DEPTH-1] & valid_q[DEPTH-1];
    assign out_branchtaken = bt_q[DEPTH-1] & valid_q[DEPTH-1];
    assign occupancy       = w_occ;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_pipe
//  Description : Directed and randomized bench for mem_wb_pipe (DEPTH=3) with a
//                slot-array model and an in-order scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_pipe;

    localparam int DEPTH = 3;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              clock = 1'b0;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic [31:0]       in_imm;
    logic [4:0]        in_rd;
    logic              in_regwrite;
    logic              in_branchtaken;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [31:0]       out_imm;
    logic [4:0]        out_rd;
    logic              out_regwrite;
    logic              out_branchtaken;
    logic [OCC_W-1:0]  occupancy;
    logic [4:0]        fwd_rs;
    logic              fwd_hit;
    logic [31:0]       fwd_data;

    mem_wb_pipe #(.DATA_W(32), .RADDR_W(5), .DEPTH(DEPTH)) u_dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_imm          (in_imm),
        .in_rd           (in_rd),
        .in_regwrite     (in_regwrite),
        .in_branchtaken  (in_branchtaken),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_imm         (out_imm),
        .out_rd          (out_rd),
        .out_regwrite    (out_regwrite),
        .out_branchtaken (out_branchtaken),
        .occupancy       (occupancy),
        .fwd_rs          (fwd_rs),
        .fwd_hit         (fwd_hit),
        .fwd_data        (fwd_data)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic        bt;
    } ent_t;

    ent_t m [DEPTH];
    ent_t sb [$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // A slot may move if the consumer takes data or any slot at/after it is empty.
    function automatic logic slot_free(input int i);
        if (out_ready) return 1'b1;
        for (int j = i; j < DEPTH; j++) if (!m[j].v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        sb.delete();
    endtask

    task automatic check_outputs();
        logic        h;
        logic [31:0] fd;
        int          occ;
        h = 1'b0; fd = '0; occ = 0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (m[i].v) occ++;
            if (m[i].v && m[i].rw && m[i].rd == fwd_rs && fwd_rs != 5'd0) begin
                h = 1'b1; fd = m[i].d;
            end
        end
        chk("in_ready", in_ready, slot_free(0) & !flush);
        chk("out_valid", out_valid, m[DEPTH-1].v);
        chk("out_regwrite", out_regwrite, m[DEPTH-1].v & m[DEPTH-1].rw);
        chk("out_branchtaken", out_branchtaken, m[DEPTH-1].v & m[DEPTH-1].bt);
        chk("occupancy", occupancy, occ);
        chk("fwd_hit", fwd_hit, h);
        chk("fwd_data", fwd_data, fd);
        if (m[DEPTH-1].v) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                chk("out_data", out_data, sb[0].d);
                chk("out_imm", out_imm, sb[0].imm);
                chk("out_rd", out_rd, sb[0].rd);
            end
        end
    endtask

    task automatic model_update();
        logic fr [DEPTH];
        for (int i = 0; i < DEPTH; i++) fr[i] = slot_free(i);
        if (m[DEPTH-1].v && out_ready) void'(sb.pop_front());
        last_acc = 1'b0;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
            sb.delete();
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) if (fr[i]) m[i] = m[i-1];
            if (fr[0]) begin
                m[0] = '{in_valid, in_data, in_imm, in_rd, in_regwrite, in_branchtaken};
                last_acc = in_valid;
                if (in_valid) sb.push_back(m[0]);
            end
        end
    endtask

    task automatic step(input logic v, input logic fl, input logic ordy, input logic [31:0] d,
                        input logic [4:0] rd, input logic rw, input logic [4:0] rs);
        @(negedge clock);
        in_valid = v; flush = fl; out_ready = ordy; in_data = d;
        in_imm = d ^ 32'hA5A5_0000; in_rd = rd; in_regwrite = rw; in_branchtaken = d[0];
        fwd_rs = rs;
        #1 check_outputs();
        @(posedge clock);
        if (!reset_n) model_clear();
        else          model_update();
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [4:0] rd, input logic rw,
                        input logic [4:0] rs, input logic ordy);
        int n = 0;
        do begin
            step(1'b1, 1'b0, ordy, d, rd, rw, rs);
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) chk("push_timeout", 0, 1);
    endtask

    task automatic bubbles(input int n, input logic ordy);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, ordy, 32'h0, 5'd0, 1'b0, 5'd0);
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_data = '0; in_imm = '0; in_rd = '0; in_regwrite = 1'b1; in_branchtaken = 1'b1;
        fwd_rs = '0;
        model_clear();
        last_acc = 1'b0;

        // Reset held with valid input pending
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 32'hCAFE_0001, 5'd5, 1'b1, 5'd5);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);
        reset_n = 1'b1;

        // Latency: accepted entry reaches the output DEPTH cycles later
        step(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 5'd5, 1'b1, 5'd0);
        bubbles(1, 1'b1);
        chk("lat_early", out_valid, 0);
        bubbles(1, 1'b1);
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 32'hDEAD_BEEF);
        chk("lat_rw", out_regwrite, 1);
        bubbles(3, 1'b1);

        // Streaming 1..8 back to back
        for (int k = 1; k <= 8; k++) push(k, 5'd1, 1'b1, 5'd1, 1'b1);
        bubbles(DEPTH + 1, 1'b1);
        chk("stream_drained", sb.size(), 0);

        // Backpressure: three fill, fourth stalls until out_ready returns
        for (int k = 1; k <= 3; k++) push(32'h100 + k, 5'd2, 1'b1, 5'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h104, 5'd2, 1'b1, 5'd0);
        chk("bp_occupancy", occupancy, 3);
        chk("bp_in_ready", in_ready, 0);
        push(32'h104, 5'd2, 1'b1, 5'd0, 1'b1);
        bubbles(DEPTH + 1, 1'b1);
        chk("bp_drained", sb.size(), 0);

        // Flush with two entries in flight
        push(32'h201, 5'd3, 1'b1, 5'd0, 1'b0);
        push(32'h202, 5'd3, 1'b1, 5'd0, 1'b0);
        chk("fl_occ_before", occupancy, 2);
        step(1'b1, 1'b1, 1'b0, 32'h203, 5'd3, 1'b1, 5'd0);
        chk("fl_occupancy", occupancy, 0);
        chk("fl_out_valid", out_valid, 0);
        bubbles(4, 1'b1);

        // Forwarding: youngest match wins, x0 never hits
        push(32'h11, 5'd7, 1'b1, 5'd7, 1'b0);
        push(32'h22, 5'd7, 1'b1, 5'd7, 1'b0);
        chk("fwd_hit7", fwd_hit, 1);
        chk("fwd_data7", fwd_data, 32'h22);
        push(32'h33, 5'd0, 1'b1, 5'd0, 1'b0);
        chk("fwd_hit0", fwd_hit, 0);
        chk("fwd_data0", fwd_data, 0);
        bubbles(4, 1'b1);

        // Asynchronous reset between edges with a full pipe
        for (int k = 1; k <= 3; k++) push(32'h300 + k, 5'd4, 1'b1, 5'd4, 1'b0);
        chk("ar_occ_before", occupancy, 3);
        #3 reset_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_occupancy", occupancy, 0);
        chk("ar_out_rw", out_regwrite, 0);
        chk("ar_fwd_hit", fwd_hit, 0);
        model_clear();
        bubbles(2, 1'b0);
        reset_n = 1'b1;
        bubbles(1, 1'b1);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 9) < 7, $urandom, 5'($urandom_range(0, 3)),
                 1'($urandom), 5'($urandom_range(0, 3)));
        end
        bubbles(DEPTH + 1, 1'b1);
        chk("rand_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
